// File: rtl/line_drawer.sv
// line_drawer: Bresenham line rasteriser that streams one pixel per accepted framebuffer write.
// Optional LINE_DRAWER_CLIP_EN: points outside the active area are stepped over instead of written.
module line_drawer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_write,
  input  logic               pixel_ready
);

  localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_DRAW = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [X_WIDTH-1:0]  cur_x_q, cur_x_d, end_x_q, end_x_d;
  logic [Y_WIDTH-1:0]  cur_y_q, cur_y_d, end_y_q, end_y_d;
  logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                sx_q, sx_d, sy_q, sy_d;

  logic [X_WIDTH-1:0]  abs_x;
  logic [Y_WIDTH-1:0]  abs_y;
  logic signed [W:0]   e2, dx_ext, dy_ext;
  logic                at_end, in_range, step;

  // e2 gets one extra bit so 2*err can never wrap.
  assign e2     = {err_q, 1'b0};
  assign dx_ext = {dx_q[W-1], dx_q};
  assign dy_ext = {dy_q[W-1], dy_q};
  assign at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

`ifdef LINE_DRAWER_CLIP_EN
  assign in_range = ({1'b0, cur_x_q} < (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS)) &&
                    ({1'b0, cur_y_q} < (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS));
`else
  assign in_range = 1'b1;
`endif

  // Off-screen points advance without waiting for the framebuffer.
  assign step        = (state_q == ST_DRAW) && (!in_range || pixel_ready);
  assign pixel_write = (state_q == ST_DRAW) && in_range;
  assign ready       = (state_q == ST_IDLE);
  assign pixel_x     = cur_x_q;
  assign pixel_y     = cur_y_q;

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    end_x_d = end_x_q;
    end_y_d = end_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    abs_x   = (end_x_q >= cur_x_q) ? end_x_q - cur_x_q : cur_x_q - end_x_q;
    abs_y   = (end_y_q >= cur_y_q) ? end_y_q - cur_y_q : cur_y_q - end_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_x_d = x1;
          cur_y_d = y1;
          end_x_d = x2;
          end_y_d = y2;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        dx_d    = W'(abs_x);
        dy_d    = -W'(abs_y);
        sx_d    = (end_x_q >= cur_x_q);
        sy_d    = (end_y_q >= cur_y_q);
        err_d   = W'(abs_x) - W'(abs_y);
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (step) begin
          if (at_end) begin
            state_d = ST_IDLE;
          end else begin
            // Both axis decisions use the same pre-update e2.
            if (e2 >= dy_ext) begin
              err_d   = err_d + dy_q;
              cur_x_d = sx_q ? cur_x_q + X_WIDTH'(1) : cur_x_q - X_WIDTH'(1);
            end
            if (e2 <= dx_ext) begin
              err_d   = err_d + dx_q;
              cur_y_d = sy_q ? cur_y_q + Y_WIDTH'(1) : cur_y_q - Y_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      end_x_q <= end_x_d;
      end_y_q <= end_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

endmodule
